// File: rtl/seg_display_ctrl.sv
// Two 16-bit counts to BCD (sequential double-dabble) driving an 8-digit
// multiplexed active-low 7-segment display, plus an egg-break status LED.
module seg_display_ctrl #(
  parameter int unsigned SCAN_DIV = 100000,
  parameter bit          LZB      = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] toss_cnt,
  input  logic [15:0] egg_cnt,
  input  logic [15:0] is_egg_break,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        egg_led,
  output logic        conv_busy
);

  localparam int unsigned BIN_W = 16;
  localparam int unsigned BCD_W = 20;
  localparam int unsigned SH_W  = BIN_W + BCD_W;
  localparam int unsigned CNT_W = $clog2(SCAN_DIV);
  localparam int unsigned ITR_W = 5;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t             r_state, w_next;
  logic [BIN_W-1:0]   r_snap_toss, r_snap_egg;
  logic [SH_W-1:0]    r_sh_toss, r_sh_egg;
  logic [ITR_W-1:0]   r_iter;
  logic [15:0]        r_disp_toss, r_disp_egg;
  logic               r_ovf_toss, r_ovf_egg;
  logic               r_busy;
  logic [CNT_W-1:0]   r_scan_cnt;
  logic [2:0]         r_digit;
  logic [7:0]         r_an;
  logic [6:0]         r_seg;
  logic               r_dp, r_led;
  logic               w_changed;
  logic [15:0]        w_grp;
  logic [1:0]         w_pos;
  logic [3:0]         w_nib;
  logic               w_blank;
  logic [7:0]         w_an;
  logic [6:0]         w_seg;
  logic               w_dp;

  // One double-dabble step: correct BCD nibbles >= 5, then shift left.
  function automatic logic [SH_W-1:0] dd_step(input logic [SH_W-1:0] v);
    logic [SH_W-1:0] t;
    t = v;
    for (int i = 0; i < 5; i++) begin
      if (t[BIN_W + 4*i +: 4] >= 4'd5) t[BIN_W + 4*i +: 4] = t[BIN_W + 4*i +: 4] + 4'd3;
    end
    return {t[SH_W-2:0], 1'b0};
  endfunction

  function automatic logic [15:0] clamp(input logic [BCD_W-1:0] b);
    return (b[19:16] != 4'd0) ? 16'h9999 : b[15:0];
  endfunction

  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0: s = 7'h40;
      4'd1: s = 7'h79;
      4'd2: s = 7'h24;
      4'd3: s = 7'h30;
      4'd4: s = 7'h19;
      4'd5: s = 7'h12;
      4'd6: s = 7'h02;
      4'd7: s = 7'h78;
      4'd8: s = 7'h00;
      4'd9: s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  assign w_changed = ({toss_cnt, egg_cnt} != {r_snap_toss, r_snap_egg});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != S_IDLE);
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_changed) w_next = S_SHIFT;
      S_SHIFT: if (r_iter == ITR_W'(1)) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Converter datapath; both groups commit together in DONE so updates never tear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_snap_toss <= '0;
      r_snap_egg  <= '0;
      r_sh_toss   <= '0;
      r_sh_egg    <= '0;
      r_iter      <= '0;
      r_disp_toss <= '0;
      r_disp_egg  <= '0;
      r_ovf_toss  <= 1'b0;
      r_ovf_egg   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_changed) begin
          r_snap_toss <= toss_cnt;
          r_snap_egg  <= egg_cnt;
          r_sh_toss   <= SH_W'(toss_cnt);
          r_sh_egg    <= SH_W'(egg_cnt);
          r_iter      <= ITR_W'(BIN_W);
        end
        S_SHIFT: begin
          r_sh_toss <= dd_step(r_sh_toss);
          r_sh_egg  <= dd_step(r_sh_egg);
          r_iter    <= r_iter - ITR_W'(1);
        end
        S_DONE: begin
          r_disp_toss <= clamp(r_sh_toss[SH_W-1 -: BCD_W]);
          r_disp_egg  <= clamp(r_sh_egg[SH_W-1 -: BCD_W]);
          r_ovf_toss  <= (r_sh_toss[SH_W-1 -: 4] != 4'd0);
          r_ovf_egg   <= (r_sh_egg[SH_W-1 -: 4] != 4'd0);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan_cnt <= '0;
      r_digit    <= '0;
    end else if (r_scan_cnt == CNT_W'(SCAN_DIV - 1)) begin
      r_scan_cnt <= '0;
      r_digit    <= r_digit + 3'd1;
    end else begin
      r_scan_cnt <= r_scan_cnt + CNT_W'(1);
    end
  end

  // Active digit decode with per-group leading-zero blanking.
  always_comb begin
    w_grp   = r_digit[2] ? r_disp_toss : r_disp_egg;
    w_pos   = r_digit[1:0];
    w_nib   = w_grp[{w_pos, 2'b00} +: 4];
    w_blank = 1'b0;
    if (LZB) begin
      case (w_pos)
        2'd3:    w_blank = (w_grp[15:12] == 4'd0);
        2'd2:    w_blank = (w_grp[15:8]  == 8'd0);
        2'd1:    w_blank = (w_grp[15:4]  == 12'd0);
        default: w_blank = 1'b0;
      endcase
    end
    w_seg = w_blank ? 7'h7F : seg_enc(w_nib);
    w_dp  = !(((r_digit == 3'd7) && r_ovf_toss) || ((r_digit == 3'd3) && r_ovf_egg));
    w_an  = ~(8'b1 << r_digit);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an  <= 8'hFF;
      r_seg <= 7'h7F;
      r_dp  <= 1'b1;
      r_led <= 1'b0;
    end else begin
      r_an  <= w_an;
      r_seg <= w_seg;
      r_dp  <= w_dp;
      r_led <= (is_egg_break != 16'd0);
    end
  end

  assign an        = r_an;
  assign seg       = r_seg;
  assign dp        = r_dp;
  assign egg_led   = r_led;
  assign conv_busy = r_busy;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Scoreboard bench for seg_display_ctrl: expected digit images are queued per
// conversion and checked by a monitor after each busy window closes.
module tb_seg_display_ctrl;

  typedef struct packed {
    logic [7:0][6:0] seg;
    logic [7:0]      dp;
  } rec_t;

  localparam logic [6:0] B = 7'h7F;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] toss_cnt, egg_cnt, is_egg_break;
  logic [7:0]  an, an0;
  logic [6:0]  seg, seg0;
  logic        dp, dp0, egg_led, egg_led0, conv_busy, conv_busy0;

  int   n_checks = 0;
  int   n_fail = 0;
  int   n_windows = 0;
  rec_t exp_q[$];

  always #5 clk = ~clk;

  seg_display_ctrl #(.SCAN_DIV(4), .LZB(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .toss_cnt(toss_cnt), .egg_cnt(egg_cnt),
    .is_egg_break(is_egg_break), .an(an), .seg(seg), .dp(dp),
    .egg_led(egg_led), .conv_busy(conv_busy)
  );

  seg_display_ctrl #(.SCAN_DIV(4), .LZB(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .toss_cnt(toss_cnt), .egg_cnt(egg_cnt),
    .is_egg_break(is_egg_break), .an(an0), .seg(seg0), .dp(dp0),
    .egg_led(egg_led0), .conv_busy(conv_busy0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic rec_t mk(input logic [6:0] d7, d6, d5, d4, d3, d2, d1, d0,
                              input logic [7:0] dpv);
    rec_t r;
    r.seg = {d7, d6, d5, d4, d3, d2, d1, d0};
    r.dp  = dpv;
    return r;
  endfunction

  task automatic check_digit(input string tag, input logic [7:0] a, input logic [6:0] s,
                             input logic d, input rec_t r);
    int idx;
    logic [7:0] m;
    idx = -1;
    for (int i = 0; i < 8; i++) begin
      m = 8'b1 << i;
      if (a == ~m) idx = i;
    end
    if (idx < 0) begin
      chk({tag, "_an_onehot"}, 32'(a), 32'hFFFF_FFFF);
    end else begin
      chk($sformatf("%s_seg_d%0d", tag, idx), 32'(s), 32'(r.seg[idx]));
      chk($sformatf("%s_dp_d%0d", tag, idx), 32'(d), 32'(r.dp[idx]));
    end
  endtask

  task automatic scan_check(input bit use0, input rec_t r, input int ncyc, input string tag);
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      if (use0) check_digit(tag, an0, seg0, dp0, r);
      else      check_digit(tag, an, seg, dp, r);
    end
  endtask

  // Monitor: a busy window closing is the output event; check the following scan.
  initial begin
    logic prev_busy;
    logic active;
    int   left;
    rec_t cur;
    prev_busy = 1'b0;
    active    = 1'b0;
    left      = 0;
    cur       = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        active    = 1'b0;
        prev_busy = 1'b0;
      end else begin
        if (active && left > 0) begin
          check_digit("mon", an, seg, dp, cur);
          left--;
        end
        if (prev_busy && !conv_busy) begin
          n_windows++;
          if (exp_q.size() == 0) begin
            chk("mon_unexpected_window", 32'(n_windows), 32'd0);
            active = 1'b0;
          end else begin
            cur    = exp_q.pop_front();
            active = 1'b1;
            left   = 32;
          end
        end
        prev_busy = conv_busy;
      end
    end
  end

  initial begin
    int         k, hi, first_hi, w0, hold;
    logic [7:0] prev_an, exp_an, m;

    // T1: reset with random inputs
    toss_cnt     = 16'($urandom);
    egg_cnt      = 16'($urandom);
    is_egg_break = 16'($urandom) | 16'h1;
    repeat (3) @(negedge clk);
    chk("t1_an", 32'(an), 32'hFF);
    chk("t1_seg", 32'(seg), 32'h7F);
    chk("t1_dp", 32'(dp), 32'd1);
    chk("t1_egg_led", 32'(egg_led), 32'd0);
    chk("t1_busy", 32'(conv_busy), 32'd0);
    toss_cnt = 16'd0; egg_cnt = 16'd0; is_egg_break = 16'd0;
    @(negedge clk);
    rst_n = 1'b1;
    scan_check(1'b0, mk(B, B, B, 7'h40, B, B, B, 7'h40, 8'hFF), 32, "t1_zero");
    chk("t1_no_conv", 32'(n_windows), 32'd0);

    // T2: latency of one conversion
    exp_q.push_back(mk(7'h79, 7'h24, 7'h30, 7'h19, B, B, B, 7'h40, 8'hFF));
    toss_cnt = 16'd1234;
    hi = 0; first_hi = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (i == 0) first_hi = int'(conv_busy);
      if (conv_busy) hi++;
    end
    chk("t2_busy_start", 32'(first_hi), 32'd1);
    chk("t2_busy_len", 32'(hi), 32'd17);
    repeat (35) @(negedge clk);

    // T3: 9999 boundary and overflow
    exp_q.push_back(mk(7'h79, 7'h24, 7'h30, 7'h19, 7'h10, 7'h10, 7'h10, 7'h10, 8'hFF));
    egg_cnt = 16'd9999;
    repeat (60) @(negedge clk);
    exp_q.push_back(mk(7'h79, 7'h24, 7'h30, 7'h19, 7'h10, 7'h10, 7'h10, 7'h10, 8'hF7));
    egg_cnt = 16'd10000;
    repeat (60) @(negedge clk);
    exp_q.push_back(mk(7'h79, 7'h24, 7'h30, 7'h19, 7'h10, 7'h10, 7'h10, 7'h10, 8'hF7));
    egg_cnt = 16'd65535;
    repeat (60) @(negedge clk);

    // T4: input change during conversion
    w0 = n_windows;
    exp_q.push_back(mk(B, B, B, 7'h12, 7'h10, 7'h10, 7'h10, 7'h10, 8'hF7));
    exp_q.push_back(mk(B, B, B, 7'h78, 7'h10, 7'h10, 7'h10, 7'h10, 8'hF7));
    toss_cnt = 16'd5;
    repeat (2) @(negedge clk);
    toss_cnt = 16'd7;
    repeat (80) @(negedge clk);
    chk("t4_two_windows", 32'(n_windows - w0), 32'd2);

    // T5: scan order and dwell
    k = 0;
    @(negedge clk);
    prev_an = an;
    while (!(an == 8'hFE && prev_an != 8'hFE) && k < 40) begin
      prev_an = an;
      @(negedge clk);
      k++;
    end
    chk("t5_sync", 32'(k < 40), 32'd1);
    for (int s = 0; s < 9; s++) begin
      m      = 8'b1 << (s % 8);
      exp_an = ~m;
      chk($sformatf("t5_an_slot%0d", s), 32'(an), 32'(exp_an));
      hold = 0;
      while (an == exp_an && hold < 10) begin
        hold++;
        @(negedge clk);
      end
      chk($sformatf("t5_hold_slot%0d", s), 32'(hold), 32'd4);
    end
    exp_q.push_back(mk(B, B, B, 7'h78, B, B, 7'h19, 7'h24, 8'hFF));
    egg_cnt = 16'd42;
    repeat (25) @(negedge clk);
    scan_check(1'b1, mk(7'h40, 7'h40, 7'h40, 7'h78, 7'h40, 7'h40, 7'h19, 7'h24, 8'hFF),
               32, "t5_nolzb");
    repeat (20) @(negedge clk);

    // T6: LED and reset mid-conversion
    is_egg_break = 16'h1;
    @(posedge clk); #1;
    chk("t6_led_on", 32'(egg_led), 32'd1);
    @(negedge clk);
    is_egg_break = 16'h0;
    @(posedge clk); #1;
    chk("t6_led_off", 32'(egg_led), 32'd0);
    repeat (40) @(negedge clk);
    toss_cnt = 16'd99;
    @(posedge clk);
    repeat (8) @(posedge clk);
    #1;
    chk("t6_busy_mid", 32'(conv_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_an", 32'(an), 32'hFF);
    chk("t6_rst_seg", 32'(seg), 32'h7F);
    chk("t6_rst_dp", 32'(dp), 32'd1);
    chk("t6_rst_busy", 32'(conv_busy), 32'd0);
    chk("t6_rst_led", 32'(egg_led), 32'd0);
    repeat (3) @(negedge clk);
    exp_q.push_back(mk(B, B, 7'h10, 7'h10, B, B, 7'h19, 7'h24, 8'hFF));
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_reconv", 32'(conv_busy), 32'd1);

    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    repeat (40) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
